// File: rtl/mandelbrot_pixel_scheduler.sv
// Mandelbrot pixel scheduler: walks an H_RES x V_RES frame in raster order,
// issues one engine job per pixel with an incrementally stepped c coordinate,
// captures the engine result and hands it downstream over valid/ready.
module mandelbrot_pixel_scheduler #(
    parameter int unsigned FIXED_POINT_WIDTH = 16,
    parameter int unsigned MAX_ITER          = 256,
    parameter int unsigned H_RES             = 160,
    parameter int unsigned V_RES             = 120,
    parameter logic [FIXED_POINT_WIDTH-1:0] X_START = 16'hE000,
    parameter logic [FIXED_POINT_WIDTH-1:0] Y_START = 16'h1000,
    parameter logic [FIXED_POINT_WIDTH-1:0] STEP    = 16'h0066
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame_start,
    input  logic                               abort,
    output logic                               eng_start,
    output logic [FIXED_POINT_WIDTH-1:0]       eng_c_real,
    output logic [FIXED_POINT_WIDTH-1:0]       eng_c_imaginary,
    input  logic                               eng_valid,
    input  logic [$clog2(MAX_ITER)-1:0]        eng_iterations,
    input  logic                               eng_is_mandelbrot,
    output logic                               pix_valid,
    input  logic                               pix_ready,
    output logic [$clog2(H_RES)-1:0]           pix_x,
    output logic [$clog2(V_RES)-1:0]           pix_y,
    output logic [$clog2(MAX_ITER)-1:0]        pix_iter,
    output logic                               pix_in_set,
    output logic                               busy,
    output logic                               frame_done
);

    localparam int unsigned FW = FIXED_POINT_WIDTH;
    localparam int unsigned IW = $clog2(MAX_ITER);
    localparam int unsigned XW = $clog2(H_RES);
    localparam int unsigned YW = $clog2(V_RES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t          r_state;
    state_t          w_state;
    logic [XW-1:0]   r_x;
    logic [XW-1:0]   w_x;
    logic [YW-1:0]   r_y;
    logic [YW-1:0]   w_y;
    logic [FW-1:0]   r_c_re;
    logic [FW-1:0]   w_c_re;
    logic [FW-1:0]   r_c_im;
    logic [FW-1:0]   w_c_im;
    logic [IW-1:0]   r_iter;
    logic [IW-1:0]   w_iter;
    logic            r_in_set;
    logic            w_in_set;
    logic            r_eng_start;
    logic            w_eng_start;
    logic            r_pix_valid;
    logic            w_pix_valid;
    logic            r_busy;
    logic            w_busy;
    logic            r_frame_done;
    logic            w_frame_done;
    logic            w_last_col;
    logic            w_last_row;

    assign w_last_col = (r_x == XW'(H_RES - 1));
    assign w_last_row = (r_y == YW'(V_RES - 1));

    // Next-state, coordinate stepping and result capture; abort overrides everything.
    always_comb begin
        w_state      = r_state;
        w_x          = r_x;
        w_y          = r_y;
        w_c_re       = r_c_re;
        w_c_im       = r_c_im;
        w_iter       = r_iter;
        w_in_set     = r_in_set;
        w_frame_done = 1'b0;

        if (abort && (r_state != S_IDLE)) begin
            w_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        w_x     = '0;
                        w_y     = '0;
                        w_c_re  = X_START;
                        w_c_im  = Y_START;
                        w_state = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_state = S_SETTLE;
                end
                // Engine valid may still reflect the previous job here.
                S_SETTLE: begin
                    w_state = S_WAIT;
                end
                S_WAIT: begin
                    if (eng_valid) begin
                        w_iter   = eng_iterations;
                        w_in_set = eng_is_mandelbrot;
                        w_state  = S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (pix_ready) begin
                        if (w_last_col && w_last_row) begin
                            w_state      = S_IDLE;
                            w_frame_done = 1'b1;
                        end else if (w_last_col) begin
                            w_x     = '0;
                            w_y     = r_y + YW'(1);
                            w_c_re  = X_START;
                            w_c_im  = r_c_im - STEP;
                            w_state = S_ISSUE;
                        end else begin
                            w_x     = r_x + XW'(1);
                            w_c_re  = r_c_re + STEP;
                            w_state = S_ISSUE;
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end

        w_eng_start = (w_state == S_ISSUE);
        w_pix_valid = (w_state == S_OUTPUT);
        w_busy      = (w_state != S_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_c_re       <= '0;
            r_c_im       <= '0;
            r_iter       <= '0;
            r_in_set     <= 1'b0;
            r_eng_start  <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_x          <= w_x;
            r_y          <= w_y;
            r_c_re       <= w_c_re;
            r_c_im       <= w_c_im;
            r_iter       <= w_iter;
            r_in_set     <= w_in_set;
            r_eng_start  <= w_eng_start;
            r_pix_valid  <= w_pix_valid;
            r_busy       <= w_busy;
            r_frame_done <= w_frame_done;
        end
    end

    assign eng_start       = r_eng_start;
    assign eng_c_real      = r_c_re;
    assign eng_c_imaginary = r_c_im;
    assign pix_valid       = r_pix_valid;
    assign pix_x           = r_x;
    assign pix_y           = r_y;
    assign pix_iter        = r_iter;
    assign pix_in_set      = r_in_set;
    assign busy            = r_busy;
    assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Scoreboard bench for mandelbrot_pixel_scheduler on a 4x2 frame with a
// behavioural engine that answers 3 cycles after each job with the job index.
module tb_mandelbrot_pixel_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        abort;
    logic        eng_start;
    logic [15:0] eng_c_real;
    logic [15:0] eng_c_imaginary;
    logic        eng_valid;
    logic [7:0]  eng_iterations;
    logic        eng_is_mandelbrot;
    logic        pix_valid;
    logic        pix_ready;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    logic [7:0]  pix_iter;
    logic        pix_in_set;
    logic        busy;
    logic        frame_done;

    mandelbrot_pixel_scheduler #(
        .FIXED_POINT_WIDTH (16),
        .MAX_ITER          (256),
        .H_RES             (4),
        .V_RES             (2),
        .X_START           (16'hE000),
        .Y_START           (16'h0400),
        .STEP              (16'h0400)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .frame_start       (frame_start),
        .abort             (abort),
        .eng_start         (eng_start),
        .eng_c_real        (eng_c_real),
        .eng_c_imaginary   (eng_c_imaginary),
        .eng_valid         (eng_valid),
        .eng_iterations    (eng_iterations),
        .eng_is_mandelbrot (eng_is_mandelbrot),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_x             (pix_x),
        .pix_y             (pix_y),
        .pix_iter          (pix_iter),
        .pix_in_set        (pix_in_set),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } job_t;

    typedef struct packed {
        logic [1:0] x;
        logic [0:0] y;
        logic [7:0] iter;
        logic       in_set;
    } pix_t;

    job_t job_q[$];
    pix_t pix_q[$];

    int n_vec    = 0;
    int n_err    = 0;
    int n_starts = 0;
    int n_pix    = 0;
    int fd_count = 0;

    logic       stale_mode = 1'b0;
    logic [2:0] eng_cnt;
    logic [7:0] eng_idx;
    logic [7:0] eng_job;

    // Behavioural engine: result 3 cycles after the start is seen; in stale mode
    // the previous result stays valid through the issue and settle cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_valid         <= 1'b0;
            eng_iterations    <= 8'd0;
            eng_is_mandelbrot <= 1'b0;
            eng_cnt           <= 3'd0;
            eng_idx           <= 8'd0;
            eng_job           <= 8'd0;
        end else begin
            if (frame_start && !busy) eng_idx <= 8'd0;
            if (eng_start) begin
                eng_cnt <= 3'd3;
                eng_job <= eng_idx;
                eng_idx <= eng_idx + 8'd1;
                if (!stale_mode) eng_valid <= 1'b0;
            end else if (eng_cnt != 3'd0) begin
                eng_cnt <= eng_cnt - 3'd1;
                if (eng_cnt == 3'd3) eng_valid <= 1'b0;
                if (eng_cnt == 3'd1) begin
                    eng_valid         <= 1'b1;
                    eng_iterations    <= eng_job;
                    eng_is_mandelbrot <= eng_job[0];
                end
            end
        end
    end

    // Scoreboard monitor: jobs checked at eng_start, pixels at handshake.
    always @(negedge clk) begin
        job_t ej;
        pix_t ep;
        if (!rst) begin
            if (eng_start) begin
                n_starts++;
                n_vec++;
                if (job_q.size() == 0) begin
                    n_err++;
                    $display("FAIL job: unexpected eng_start c=%h/%h", eng_c_real, eng_c_imaginary);
                end else begin
                    ej = job_q.pop_front();
                    if ({eng_c_real, eng_c_imaginary} !== {ej.re, ej.im}) begin
                        n_err++;
                        $display("FAIL job_c: got %h/%h expected %h/%h", eng_c_real, eng_c_imaginary, ej.re, ej.im);
                    end
                end
            end
            if (pix_valid && pix_ready && !abort) begin
                n_pix++;
                n_vec++;
                if (pix_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pixel: unexpected handshake x=%0d y=%0d", pix_x, pix_y);
                end else begin
                    ep = pix_q.pop_front();
                    if ({pix_x, pix_y, pix_iter, pix_in_set} !== {ep.x, ep.y, ep.iter, ep.in_set}) begin
                        n_err++;
                        $display("FAIL pixel: got x=%0d y=%0d it=%0d s=%0b expected x=%0d y=%0d it=%0d s=%0b",
                                 pix_x, pix_y, pix_iter, pix_in_set, ep.x, ep.y, ep.iter, ep.in_set);
                    end
                end
            end
            if (frame_done) begin
                fd_count++;
                n_vec++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_busy: busy=%b with frame_done, expected 0", busy);
                end
            end
        end
    end

    task automatic push_frame();
        job_t j;
        pix_t p;
        logic [15:0] re;
        logic [15:0] im;
        im = 16'h0400;
        for (int y = 0; y < 2; y++) begin
            re = 16'hE000;
            for (int x = 0; x < 4; x++) begin
                j.re     = re;
                j.im     = im;
                p.x      = 2'(x);
                p.y      = 1'(y);
                p.iter   = 8'(y * 4 + x);
                p.in_set = p.iter[0];
                job_q.push_back(j);
                pix_q.push_back(p);
                re = re + 16'h0400;
            end
            im = im - 16'h0400;
        end
    endtask

    task automatic pulse_frame_start();
        @(posedge clk) #2;
        frame_start = 1'b1;
        @(posedge clk) #2;
        frame_start = 1'b0;
    endtask

    task automatic wait_starts(input int target, input string tag);
        int k = 0;
        while (n_starts < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (n_starts < target) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout waiting eng_start count %0d, have %0d", tag, target, n_starts);
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (fd_count < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (fd_count < target) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout waiting frame_done, count %0d expected %0d", tag, fd_count, target);
        end
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({eng_start, eng_c_real, eng_c_imaginary, pix_valid, pix_x, pix_y, pix_iter, pix_in_set, frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got c=%h/%h st=%b pv=%b it=%h expected all 0",
                     eng_c_real, eng_c_imaginary, eng_start, pix_valid, pix_iter);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (eng_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL idle_quiet: activity without frame_start, expected none");
        end
    endtask

    task automatic test_full_frame();
        int fd0 = fd_count;
        int p0  = n_pix;
        stale_mode = 1'b0;
        pix_ready  = 1'b1;
        push_frame();
        @(posedge clk) #2;
        frame_start = 1'b1;
        @(posedge clk) #2;
        frame_start = 1'b0;
        n_vec++;
        if ({eng_start, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL start_latency: eng_start/busy=%b%b expected 11", eng_start, busy);
        end
        wait_done(fd0 + 1, "full_frame");
        repeat (5) @(negedge clk);
        n_vec++;
        if (n_pix - p0 != 8) begin
            n_err++;
            $display("FAIL full_frame_count: got %0d pixels expected 8", n_pix - p0);
        end
        n_vec++;
        if (fd_count - fd0 != 1) begin
            n_err++;
            $display("FAIL full_frame_done: got %0d pulses expected 1", fd_count - fd0);
        end
    endtask

    task automatic test_backpressure();
        int fd0 = fd_count;
        int s0  = n_starts;
        int k   = 0;
        logic [11:0] held;
        pix_ready = 1'b1;
        push_frame();
        pulse_frame_start();
        wait_starts(s0 + 3, "bp_issue");
        @(posedge clk) #2;
        pix_ready = 1'b0;
        while (pix_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if ({pix_valid, pix_x, pix_y, pix_iter} !== {1'b1, 2'd2, 1'd0, 8'd2}) begin
            n_err++;
            $display("FAIL bp_present: got v=%b x=%0d y=%0d it=%0d expected v=1 x=2 y=0 it=2",
                     pix_valid, pix_x, pix_y, pix_iter);
        end
        held = {pix_x, pix_y, pix_iter, pix_in_set};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({pix_valid, eng_start, pix_x, pix_y, pix_iter, pix_in_set} !== {1'b1, 1'b0, held}) begin
                n_err++;
                $display("FAIL bp_hold: cycle %0d v=%b st=%b data=%h expected v=1 st=0 data=%h",
                         i, pix_valid, eng_start, {pix_x, pix_y, pix_iter, pix_in_set}, held);
            end
        end
        @(posedge clk) #2;
        pix_ready = 1'b1;
        wait_done(fd0 + 1, "bp_frame");
        repeat (3) @(negedge clk);
        n_vec++;
        if (job_q.size() != 0 || pix_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: %0d jobs %0d pixels left expected 0", job_q.size(), pix_q.size());
        end
    endtask

    task automatic test_stale_valid();
        int fd0 = fd_count;
        int p0  = n_pix;
        stale_mode = 1'b1;
        pix_ready  = 1'b1;
        push_frame();
        pulse_frame_start();
        wait_done(fd0 + 1, "stale_frame");
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_pix - p0 != 8 || pix_q.size() != 0) begin
            n_err++;
            $display("FAIL stale_count: got %0d pixels (%0d left) expected 8 (0)", n_pix - p0, pix_q.size());
        end
        stale_mode = 1'b0;
    endtask

    task automatic test_abort();
        int fd0 = fd_count;
        int s0  = n_starts;
        int k   = 0;
        logic bad;
        pix_ready = 1'b1;
        push_frame();
        pulse_frame_start();
        wait_starts(s0 + 3, "abort_mid");
        pulse_frame_start();
        wait_starts(s0 + 6, "abort_p5");
        @(posedge clk) #2;
        pix_ready = 1'b0;
        while (pix_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if ({pix_x, pix_y, pix_iter} !== {2'd1, 1'd1, 8'd5}) begin
            n_err++;
            $display("FAIL abort_pixel5: got x=%0d y=%0d it=%0d expected x=1 y=1 it=5", pix_x, pix_y, pix_iter);
        end
        @(posedge clk) #2;
        abort       = 1'b1;
        pix_ready   = 1'b1;
        frame_start = 1'b1;
        @(posedge clk) #2;
        abort       = 1'b0;
        frame_start = 1'b0;
        job_q.delete();
        pix_q.delete();
        n_vec++;
        if ({busy, pix_valid, frame_done, eng_start} !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_idle: busy/pv/done/st=%b%b%b%b expected 0000", busy, pix_valid, frame_done, eng_start);
        end
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy !== 1'b0 || frame_done !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad || fd_count != fd0) begin
            n_err++;
            $display("FAIL abort_no_done: done pulses %0d expected 0", fd_count - fd0);
        end
        push_frame();
        pulse_frame_start();
        #1;
        n_vec++;
        if ({eng_start, eng_c_real, eng_c_imaginary, pix_x, pix_y} !== {1'b1, 16'hE000, 16'h0400, 2'd0, 1'd0}) begin
            n_err++;
            $display("FAIL abort_restart: st=%b c=%h/%h x=%0d y=%0d expected 1 E000/0400 0 0",
                     eng_start, eng_c_real, eng_c_imaginary, pix_x, pix_y);
        end
        wait_done(fd0 + 1, "abort_restart_frame");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int s0 = n_starts;
        logic bad;
        pix_ready = 1'b1;
        push_frame();
        pulse_frame_start();
        wait_starts(s0 + 2, "rst_wait");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, eng_start, eng_c_real, eng_c_imaginary, pix_valid, pix_x, pix_y, pix_iter, pix_in_set, frame_done} !== '0) begin
            n_err++;
            $display("FAIL rst_async: busy=%b c=%h/%h x=%0d it=%0d expected all 0",
                     busy, eng_c_real, eng_c_imaginary, pix_x, pix_iter);
        end
        job_q.delete();
        pix_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || pix_valid !== 1'b0 || frame_done !== 1'b0 || eng_start !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL rst_idle: activity after reset release, expected idle");
        end
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        abort       = 1'b0;
        pix_ready   = 1'b0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_stale_valid();
        test_abort();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
